// File: rtl/om_dst_fetch.sv
// Destination-colour fetch ahead of the OM blend unit: one masked read per batch,
// batches parked in an in-order slot ring and released once their dst colours land.
module om_dst_fetch #(
  parameter int NUM_LANES  = 4,
  parameter int TAG_WIDTH  = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int QUEUE_SIZE = 4,
  localparam int QW        = $clog2(QUEUE_SIZE)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  input  logic [NUM_LANES-1:0]            mask_in,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_LANES*32-1:0]         src_color_in,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [NUM_LANES-1:0]            mem_req_mask,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] mem_req_addr,
  output logic [QW-1:0]                   mem_req_tag,
  input  logic                            mem_rsp_valid,
  input  logic [NUM_LANES*32-1:0]         mem_rsp_data,
  output logic                            mem_rsp_ready,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic [TAG_WIDTH-1:0]            tag_out,
  output logic [NUM_LANES-1:0]            mask_out,
  output logic [NUM_LANES*32-1:0]         src_color_out,
  output logic [NUM_LANES*32-1:0]         dst_color_out
);

  logic [TAG_WIDTH-1:0]    tag_q  [QUEUE_SIZE];
  logic [NUM_LANES-1:0]    mask_q [QUEUE_SIZE];
  logic [NUM_LANES*32-1:0] src_q  [QUEUE_SIZE];
  logic [NUM_LANES*32-1:0] dst_q  [QUEUE_SIZE];

  logic [QUEUE_SIZE-1:0] valid_q, valid_d, need_q, need_d, done_q, done_d;
  logic [QW-1:0]         head_q, head_d, tail_q, tail_d, rsp_ptr;
  logic [QW:0]           count_q, count_d;
  logic                  full, any_lane, push, pop, rsp_found, rsp_fire;
  logic [NUM_LANES*32-1:0] rsp_masked;

  assign full          = (count_q == (QW+1)'(QUEUE_SIZE));
  assign any_lane      = |mask_in;
  assign ready_in      = !reset && !full && (!any_lane || mem_req_ready);
  assign mem_req_valid = !reset && valid_in && !full && any_lane;
  assign mem_req_mask  = mask_in;
  assign mem_req_addr  = addr_in;
  assign mem_req_tag   = tail_q;
  assign mem_rsp_ready = !reset;
  assign push          = valid_in && ready_in;

  assign valid_out     = valid_q[head_q] && done_q[head_q];
  assign pop           = valid_out && ready_out;
  assign tag_out       = tag_q[head_q];
  assign mask_out      = mask_q[head_q];
  assign src_color_out = src_q[head_q];
  assign dst_color_out = dst_q[head_q];

  // Responses return in request order, so the target is the oldest slot still awaiting data.
  always_comb begin
    logic [QW-1:0] idx;
    rsp_found = 1'b0;
    rsp_ptr   = head_q;
    for (int i = QUEUE_SIZE-1; i >= 0; i--) begin
      idx = head_q + QW'(i);
      if (valid_q[idx] && need_q[idx] && !done_q[idx]) begin
        rsp_found = 1'b1;
        rsp_ptr   = idx;
      end
    end
  end

  assign rsp_fire = mem_rsp_valid && rsp_found;

  always_comb begin
    rsp_masked = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (mask_q[rsp_ptr][l]) rsp_masked[l*32 +: 32] = mem_rsp_data[l*32 +: 32];
  end

  always_comb begin
    valid_d = valid_q;
    need_d  = need_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (QW+1)'(push) - (QW+1)'(pop);
    if (rsp_fire) done_d[rsp_ptr] = 1'b1;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      need_d[tail_q]  = any_lane;
      done_d[tail_q]  = !any_lane;
      tail_d          = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      need_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      need_q  <= need_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind valid/done.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= tag_in;
      mask_q[tail_q] <= mask_in;
      src_q[tail_q]  <= src_color_in;
      dst_q[tail_q]  <= '0;
    end
    if (rsp_fire) dst_q[rsp_ptr] <= rsp_masked;
  end

  a_rsp_outstanding: assert property (@(posedge clk) disable iff (reset)
    mem_rsp_valid |-> rsp_found);

endmodule

// File: tb/tb_om_dst_fetch.sv
// Scoreboard bench for om_dst_fetch: stimulus pushes expected pairs, a monitor pops on each handshake.
module tb_om_dst_fetch;
  localparam int NL = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in, ready_in, mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic          valid_out, ready_out;
  logic [TW-1:0] tag_in, tag_out;
  logic [NL-1:0] mask_in, mem_req_mask, mask_out;
  logic [127:0]  addr_in, mem_req_addr, src_color_in, mem_rsp_data, src_color_out, dst_color_out;
  logic [1:0]    mem_req_tag;

  om_dst_fetch #(.NUM_LANES(NL), .TAG_WIDTH(TW), .ADDR_WIDTH(32), .QUEUE_SIZE(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in),
    .mask_in(mask_in), .addr_in(addr_in), .src_color_in(src_color_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_mask(mem_req_mask),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready), .valid_out(valid_out),
    .ready_out(ready_out), .tag_out(tag_out), .mask_out(mask_out),
    .src_color_out(src_color_out), .dst_color_out(dst_color_out));

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [NL-1:0] mask;
    logic [127:0]  src;
    logic [127:0]  dst;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [1:0] tb_tail = 2'd0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] base);
    logic [127:0] v;
    for (int i = 0; i < NL; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one batch and waits (bounded) for it to be accepted.
  task automatic send(input logic [TW-1:0] tag, input logic [NL-1:0] mask,
                      input logic [31:0] abase, input logic [31:0] sbase, input logic [127:0] edst);
    exp_t e;
    int   n;
    valid_in = 1'b1; tag_in = tag; mask_in = mask;
    addr_in = lanes(abase); src_color_in = lanes(sbase);
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) begin
      n_total++;
      $display("FAIL send_accept: ready_in stayed 0 for tag %0d", tag);
    end else begin
      if (mask != 0) begin
        chk("req_valid", 128'(mem_req_valid), 128'd1);
        chk("req_tag", 128'(mem_req_tag), 128'(tb_tail));
        chk("req_addr", mem_req_addr, lanes(abase));
        chk("req_mask", 128'(mem_req_mask), 128'(mask));
      end else begin
        chk("req_valid_empty", 128'(mem_req_valid), 128'd0);
      end
      e.tag = tag; e.mask = mask; e.src = lanes(sbase); e.dst = edst;
      sb.push_back(e);
      tb_tail = tb_tail + 2'd1;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0; mask_in = '0;
  endtask

  task automatic respond(input logic [127:0] data);
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL out_unexpected: valid_out with tag %0d and nothing expected", tag_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_tag", 128'(tag_out), 128'(e.tag));
        chk("out_mask", 128'(mask_out), 128'(e.mask));
        chk("out_src", src_color_out, e.src);
        chk("out_dst", dst_color_out, e.dst);
      end
    end
  end

  initial begin
    reset = 1'b1; valid_in = 1'b1; tag_in = '0; mask_in = 4'b1111; addr_in = '0;
    src_color_in = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    ready_out = 1'b1;
    repeat (2) tick();
    chk("rst_ready_in", 128'(ready_in), 128'd0);
    chk("rst_req_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_valid_out", 128'(valid_out), 128'd0);
    chk("rst_rsp_ready", 128'(mem_rsp_ready), 128'd0);
    valid_in = 1'b0; mask_in = '0;
    reset = 1'b0;
    tick();
    chk("post_rst_rsp_ready", 128'(mem_rsp_ready), 128'd1);
    chk("post_rst_valid_out", 128'(valid_out), 128'd0);

    // full mask, response three cycles after the request
    send(2'd1, 4'b1111, 32'h100, 32'hA000_0000, {4{32'hFF00FF00}});
    tick(); tick();
    respond({4{32'hFF00FF00}});
    chk("t1_valid_after_rsp", 128'(valid_out), 128'd1);
    tick();
    chk("t1_valid_after_pop", 128'(valid_out), 128'd0);

    // partial mask zeroes lanes 1 and 3
    send(2'd0, 4'b0101, 32'h200, 32'hB000_0000, {32'h0, 32'h11111111, 32'h0, 32'h11111111});
    tick();
    respond({4{32'h11111111}});
    tick();

    // empty batch waits behind a pending read
    send(2'd1, 4'b0011, 32'h300, 32'hC000_0000, {32'h0, 32'h0, 32'h22222222, 32'h22222222});
    send(2'd0, 4'b0000, 32'h400, 32'hD000_0000, 128'd0);
    tick();
    chk("t3_empty_waits", 128'(valid_out), 128'd0);
    tick();
    chk("t3_empty_waits2", 128'(valid_out), 128'd0);
    respond({4{32'h22222222}});
    chk("t3_read_first", 128'(valid_out), 128'd1);
    chk("t3_read_tag", 128'(tag_out), 128'd1);
    tick();
    chk("t3_empty_next", 128'(valid_out), 128'd1);
    chk("t3_empty_tag", 128'(tag_out), 128'd0);
    tick();
    chk("t3_drained", 128'(valid_out), 128'd0);

    // fill all four slots with output stalled
    ready_out = 1'b0;
    for (int k = 0; k < 4; k++)
      send(TW'(k), 4'b1111, 32'h500 + 32'(k*16), 32'hE000_0000 + 32'(k*16),
           {4{32'h3000_0000 + 32'(k)}});
    valid_in = 1'b1; mask_in = 4'b1111; mem_req_ready = 1'b1;
    #1;
    chk("full_ready_in", 128'(ready_in), 128'd0);
    chk("full_req_valid", 128'(mem_req_valid), 128'd0);
    mask_in = 4'b0000;
    #1;
    chk("full_ready_in_empty", 128'(ready_in), 128'd0);
    valid_in = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) respond({4{32'h3000_0000 + 32'(k)}});
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 128'(valid_out), 128'd1);
      chk("stall_tag", 128'(tag_out), 128'd0);
      tick();
    end
    ready_out = 1'b1;
    tick();
    chk("pop_frees_slot", 128'(ready_in), 128'd1);
    repeat (4) tick();

    // request side stalled: read batch refused, empty batch still goes through
    mem_req_ready = 1'b0;
    valid_in = 1'b1; mask_in = 4'b1111; addr_in = lanes(32'h600);
    #1;
    chk("noreq_ready_in", 128'(ready_in), 128'd0);
    chk("noreq_req_valid", 128'(mem_req_valid), 128'd1);
    tick();
    valid_in = 1'b0; mask_in = '0;
    chk("noreq_no_slot", 128'(valid_out), 128'd0);
    send(2'd3, 4'b0000, 32'h700, 32'hF000_0000, 128'd0);
    chk("empty_latency", 128'(valid_out), 128'd1);
    mem_req_ready = 1'b1;
    tick();

    // back-to-back empty batches at full rate
    send(2'd2, 4'b0000, 32'h800, 32'h1000_0000, 128'd0);
    send(2'd1, 4'b0000, 32'h810, 32'h2000_0000, 128'd0);
    send(2'd0, 4'b0000, 32'h820, 32'h3000_0000, 128'd0);

    for (int c = 0; c < 50 && sb.size() != 0; c++) tick();
    tick();
    chk("sb_drained", 128'(sb.size()), 128'd0);
    chk("end_valid_out", 128'(valid_out), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
